// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin front end that shares one 8-bit ALU among NREQ
// requesters. It grants one request at a time and drives a single-cycle issue
// strobe into the ALU. It waits the ALU's fixed latency, captures the result
// and flags, and returns them tagged with the requester id. It also produces
// the ALU's synchronous reset from the block's asynchronous reset.
module alu_rr_sched #(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = 1,
  parameter int IDW     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  // request side
  input  logic [NREQ-1:0]     req_valid,
  input  logic [5*NREQ-1:0]   req_opcode,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]     req_carry,
  input  logic [NREQ-1:0]     req_borrow,
  output logic [NREQ-1:0]     req_ready,
  // response side
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_result,
  output logic [4:0]          rsp_flags,
  output logic                rsp_err,
  // ALU side
  output logic                alu_rst,
  output logic                alu_enable,
  output logic                alu_input_ready,
  output logic [4:0]          alu_opcode,
  output logic [7:0]          alu_operand_a,
  output logic [7:0]          alu_operand_b,
  output logic                alu_carry_in,
  output logic                alu_borrow_in,
  input  logic [7:0]          alu_result,
  input  logic                alu_carry_out,
  input  logic                alu_borrow_out,
  input  logic                alu_overflow,
  input  logic                alu_zero,
  input  logic                alu_negative
);

  // Highest opcode the ALU implements; anything above is answered locally.
  localparam logic [4:0] MAX_OPCODE = 5'd19;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_reg, state_next;

  // Two-flop reset synchronizer for the ALU; bit 0 is the first stage.
  logic [1:0] rst_sync_reg;

  // Round-robin pointer: last requester granted.
  logic [IDW-1:0] ptr_reg;

  // Operation latched at grant time.
  logic [4:0]     op_reg;
  logic [7:0]     a_reg;
  logic [7:0]     b_reg;
  logic           cin_reg;
  logic           bin_reg;
  logic [IDW-1:0] id_reg;

  // Response captured from the ALU (or synthesized for an illegal opcode).
  logic [7:0]     res_reg;
  logic [4:0]     flags_reg;
  logic           err_reg;

  // Latency counter; ALU_LAT is at most 7.
  logic [2:0]     cnt_reg;

  // Per-requester views of the packed request buses.
  logic [4:0] opc_arr [NREQ];
  logic [7:0] a_arr   [NREQ];
  logic [7:0] b_arr   [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign opc_arr[gi] = req_opcode[5*gi +: 5];
      assign a_arr[gi]   = req_a[8*gi +: 8];
      assign b_arr[gi]   = req_b[8*gi +: 8];
    end
  endgenerate

  // Arbiter result for the current cycle.
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           grant_legal;

  // Search upward from ptr+1 with wrap-around for the first active request.
  always_comb begin
    int j;
    logic [IDW-1:0] idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    j           = 0;
    idx         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr_reg) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      idx = IDW'(j);
      if (!grant_valid && req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign grant_legal = (opc_arr[grant_id] <= MAX_OPCODE);

  // ALU reset: held high during rst_n, released on the 2nd edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 2'b11;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b0};
    end
  end

  assign alu_rst = rst_sync_reg[1];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and all state-qualified outputs.
  always_comb begin
    state_next      = state_reg;
    req_ready       = '0;
    alu_enable      = 1'b0;
    alu_input_ready = 1'b0;
    alu_opcode      = '0;
    alu_operand_a   = '0;
    alu_operand_b   = '0;
    alu_carry_in    = 1'b0;
    alu_borrow_in   = 1'b0;
    rsp_valid       = 1'b0;
    rsp_id          = '0;
    rsp_result      = '0;
    rsp_flags       = '0;
    rsp_err         = 1'b0;
    case (state_reg)
      S_INIT: begin
        // Leave INIT on the same edge that drops alu_rst.
        if (!rst_sync_reg[0]) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (grant_valid) begin
          req_ready[grant_id] = 1'b1;
          state_next = grant_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        alu_enable      = 1'b1;
        alu_input_ready = 1'b1;
        alu_opcode      = op_reg;
        alu_operand_a   = a_reg;
        alu_operand_b   = b_reg;
        alu_carry_in    = cin_reg;
        alu_borrow_in   = bin_reg;
        state_next      = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_reg == 3'd1) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid  = 1'b1;
        rsp_id     = id_reg;
        rsp_result = res_reg;
        rsp_flags  = flags_reg;
        rsp_err    = err_reg;
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  // Datapath: latch the granted op, count the ALU latency, capture results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= IDW'(NREQ - 1);
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      bin_reg   <= 1'b0;
      id_reg    <= '0;
      res_reg   <= '0;
      flags_reg <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_valid) begin
            ptr_reg <= grant_id;
            id_reg  <= grant_id;
            op_reg  <= opc_arr[grant_id];
            a_reg   <= a_arr[grant_id];
            b_reg   <= b_arr[grant_id];
            cin_reg <= req_carry[grant_id];
            bin_reg <= req_borrow[grant_id];
            if (!grant_legal) begin
              // Answered without touching the ALU.
              res_reg   <= '0;
              flags_reg <= '0;
              err_reg   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          cnt_reg <= 3'(ALU_LAT);
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            // ALU outputs are taken verbatim; no flag recomputation here.
            res_reg   <= alu_result;
            flags_reg <= {alu_carry_out, alu_borrow_out, alu_overflow,
                          alu_zero, alu_negative};
            err_reg   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
